// File: rtl/paddle_control.sv
// Per-player paddle position: synchronised buttons drive a per-frame FSM with velocity ramp and screen clamping.
// Optional `PADDLE_AI_EN adds ai_mode/y_pos_of_ball so the paddle can track the ball instead of the buttons.
module paddle_control #(
    parameter int INIT_POS     = 384,
    parameter int PADDLE_HALF  = 48,
    parameter int SCREEN_H     = 768,
    parameter int V_MIN        = 2,
    parameter int V_MAX        = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        end_of_frame,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        screen_idle,
`ifdef PADDLE_AI_EN
    input  logic        ai_mode,
    input  logic [10:0] y_pos_of_ball,
`endif
    output logic [9:0]  pos_of_player
);

    localparam int VW      = $clog2(V_MAX + 1);
    localparam int CW      = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam int POS_MIN = PADDLE_HALF;
    localparam int POS_MAX = SCREEN_H - 1 - PADDLE_HALF;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

    state_t          state, state_next, dir;
    logic [VW-1:0]   vel, vel_next, step_vel;
    logic [CW-1:0]   frame_cnt, cnt_next, step_cnt;
    logic [9:0]      pos_next;
    logic signed [10:0] pos_wide;
    logic [1:0]      up_sync, down_sync;
    logic            up_s, down_s, want_up, want_down;

    assign up_s   = up_sync[1];
    assign down_s = down_sync[1];

`ifdef PADDLE_AI_EN
    logic signed [11:0] ball_s, pos_s;
    assign ball_s = signed'({1'b0, y_pos_of_ball});
    assign pos_s  = signed'({2'b00, pos_of_player});
    assign want_up   = ai_mode ? (ball_s < pos_s - 12'sd8) : up_s;
    assign want_down = ai_mode ? (ball_s > pos_s + 12'sd8) : down_s;
`else
    assign want_up   = up_s;
    assign want_down = down_s;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        vel_next   = vel;
        cnt_next   = frame_cnt;
        pos_next   = pos_of_player;
        dir        = IDLE;
        step_vel   = vel;
        step_cnt   = frame_cnt;
        pos_wide   = '0;
        if (screen_idle) begin
            state_next = IDLE;
            vel_next   = VW'(V_MIN);
            cnt_next   = '0;
            pos_next   = 10'(INIT_POS);
        end else if (end_of_frame) begin
            if (want_up ^ want_down) begin
                dir = want_up ? MOVE_UP : MOVE_DOWN;
                // A fresh direction always restarts the ramp, including this frame's move.
                if (state != dir) begin
                    step_vel = VW'(V_MIN);
                    step_cnt = '0;
                end
                if (want_up)
                    pos_wide = signed'({1'b0, pos_of_player}) - signed'(11'(step_vel));
                else
                    pos_wide = signed'({1'b0, pos_of_player}) + signed'(11'(step_vel));
                if (pos_wide < POS_MIN)
                    pos_next = 10'(POS_MIN);
                else if (pos_wide > POS_MAX)
                    pos_next = 10'(POS_MAX);
                else
                    pos_next = pos_wide[9:0];
                state_next = dir;
                if (step_cnt == CW'(ACCEL_FRAMES - 1)) begin
                    cnt_next = '0;
                    vel_next = (step_vel < VW'(V_MAX)) ? step_vel + 1'b1 : step_vel;
                end else begin
                    cnt_next = step_cnt + 1'b1;
                    vel_next = step_vel;
                end
            end else begin
                state_next = IDLE;
                vel_next   = VW'(V_MIN);
                cnt_next   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk65MHz or posedge rst) begin
        if (rst) begin
            up_sync       <= '0;
            down_sync     <= '0;
            state         <= IDLE;
            vel           <= VW'(V_MIN);
            frame_cnt     <= '0;
            pos_of_player <= 10'(INIT_POS);
        end else begin
            up_sync       <= {up_sync[0], btn_up};
            down_sync     <= {down_sync[0], btn_down};
            state         <= state_next;
            vel           <= vel_next;
            frame_cnt     <= cnt_next;
            pos_of_player <= pos_next;
        end
    end

endmodule
